fault_test_ctrl: RTL and testbench

//  Exhaustive test-sequencing controller for a small combinational circuit-under-test (CUT).

---
 rtl/fault_test_ctrl.sv | 99 +++++++++
 tb/tb_fault_test_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fault_test_ctrl.sv
// Exhaustive test sequencer: walks every input vector through a CUT and its golden copy,
// holds each vector SETTLE cycles, then counts output mismatches and records the first one.
module fault_test_ctrl #(
  parameter int NUM_IN = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop_on_fail,
  input  logic              cut_out,
  input  logic              ref_out,
  output logic [NUM_IN-1:0] vec,
  output logic              busy,
  output logic              done,
  output logic              fault_detected,
  output logic [NUM_IN:0]   fail_count,
  output logic [NUM_IN-1:0] first_fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          stop_latched;
  logic          mismatch;
  logic          last_vec;

  always_comb begin
    mismatch = (cut_out != ref_out);
    last_vec = &vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      stop_latched   <= 1'b0;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fault_detected <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_WAIT;
            vec            <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            fault_detected <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            stop_latched   <= stop_on_fail;
          end
        end
        S_WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_COMPARE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_COMPARE: begin
          if (mismatch) begin
            fail_count <= fail_count + 1'b1;
            if (!fault_detected) begin
              first_fail_vec <= vec;
              fault_detected <= 1'b1;
            end
          end
          // vec stops at all-ones (or at the failing vector) so it reports where the run ended
          if (last_vec || (mismatch && stop_latched)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            vec        <= vec + 1'b1;
            settle_cnt <= '0;
            state      <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_test_ctrl.sv
// Directed bench: one instance with SETTLE=1 on a selectable good/faulty CUT,
// one with SETTLE=3 on an always-inverted CUT.
module tb_fault_test_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stop_on_fail = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  int         mode1 = 0;
  int         cur = 0;
  int         compares = 0;
  int         errors = 0;
  int         cyc;

  logic       cut1, ref1, cut2, ref2;
  logic [3:0] vec1, vec2, ffv1, ffv2;
  logic       busy1, busy2, done1, done2, fd1, fd2;
  logic [4:0] fc1, fc2;

  logic [3:0] vec_s, ffv_s;
  logic       busy_s, done_s, fd_s;
  logic [4:0] fc_s;

  always #5 clk = ~clk;

  // l = e & ((a&b) | ~(b&c)), with {a,b,c,e} = v[3:0]
  function automatic logic golden(input logic [3:0] v);
    return v[0] & ((v[3] & v[2]) | ~(v[2] & v[1]));
  endfunction

  always_comb begin
    ref1 = golden(vec1);
    ref2 = golden(vec2);
    case (mode1)
      1:       cut1 = vec1[0];
      2:       cut1 = ~ref1;
      default: cut1 = ref1;
    endcase
    cut2 = ~ref2;
    if (cur == 1) begin
      vec_s = vec2; ffv_s = ffv2; busy_s = busy2; done_s = done2; fd_s = fd2; fc_s = fc2;
    end else begin
      vec_s = vec1; ffv_s = ffv1; busy_s = busy1; done_s = done1; fd_s = fd1; fc_s = fc1;
    end
  end

  fault_test_ctrl #(.NUM_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop_on_fail(stop_on_fail),
    .cut_out(cut1), .ref_out(ref1), .vec(vec1), .busy(busy1), .done(done1),
    .fault_detected(fd1), .fail_count(fc1), .first_fail_vec(ffv1)
  );

  fault_test_ctrl #(.NUM_IN(4), .SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop_on_fail(stop_on_fail),
    .cut_out(cut2), .ref_out(ref2), .vec(vec2), .busy(busy2), .done(done2),
    .fault_detected(fd2), .fail_count(fc2), .first_fail_vec(ffv2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start2 = v; else start1 = v;
  endtask

  // Starts a run on instance sel; optionally re-pulses start mid-run (with stop_on_fail=1)
  // at cycle mid_at. Returns cycles from the start edge to the first cycle done is high.
  task automatic run(input int sel, input logic stop, input int mid_at, output int cycles);
    int n;
    cur = sel;
    @(negedge clk);
    stop_on_fail = stop;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check("start_vec", 32'(vec_s), 0);
    check("start_busy", 32'(busy_s), 1);
    check("start_done", 32'(done_s), 0);
    check("start_fcnt", 32'(fc_s), 0);
    check("start_fdet", 32'(fd_s), 0);
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (done_s) break;
      if (n == mid_at) begin
        set_start(sel, 1'b1);
        stop_on_fail = 1'b1;
      end else begin
        set_start(sel, 1'b0);
      end
    end
    set_start(sel, 1'b0);
    check("run_done", 32'(done_s), 1);
    check("run_busy", 32'(busy_s), 0);
    cycles = n;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec1", 32'(vec1), 0);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_done1", 32'(done1), 0);
    check("rst_fd1", 32'(fd1), 0);
    check("rst_fc1", 32'(fc1), 0);
    check("rst_ffv1", 32'(ffv1), 0);
    check("rst_done2", 32'(done2), 0);
    check("rst_fc2", 32'(fc2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1 fault-free
    mode1 = 0;
    run(0, 1'b0, -1, cyc);
    check("t1_cycles", 32'(cyc), 32);
    check("t1_fcnt", 32'(fc1), 0);
    check("t1_fdet", 32'(fd1), 0);
    check("t1_vec", 32'(vec1), 4'hf);

    // T2 faulty CUT, full run
    mode1 = 1;
    run(0, 1'b0, -1, cyc);
    check("t2_cycles", 32'(cyc), 32);
    check("t2_fcnt", 32'(fc1), 1);
    check("t2_ffv", 32'(ffv1), 4'b0111);
    check("t2_fdet", 32'(fd1), 1);
    check("t2_vec", 32'(vec1), 4'hf);

    // hold results in DONE
    repeat (4) @(posedge clk);
    #1;
    check("hold_done", 32'(done1), 1);
    check("hold_fcnt", 32'(fc1), 1);
    check("hold_ffv", 32'(ffv1), 4'b0111);

    // T6 back-to-back start from DONE
    run(0, 1'b0, -1, cyc);
    check("t6_cycles", 32'(cyc), 32);
    check("t6_fcnt", 32'(fc1), 1);
    check("t6_ffv", 32'(ffv1), 4'b0111);
    check("t6_fdet", 32'(fd1), 1);

    // T3 stop on first fail
    run(0, 1'b1, -1, cyc);
    check("t3_cycles", 32'(cyc), 16);
    check("t3_vec", 32'(vec1), 4'b0111);
    check("t3_fcnt", 32'(fc1), 1);
    check("t3_ffv", 32'(ffv1), 4'b0111);

    // T5 start re-pulsed mid-run is ignored
    run(0, 1'b0, 5, cyc);
    check("t5_cycles", 32'(cyc), 32);
    check("t5_fcnt", 32'(fc1), 1);
    check("t5_ffv", 32'(ffv1), 4'b0111);
    check("t5_vec", 32'(vec1), 4'hf);

    // T5 async reset mid-run
    cur = 0;
    @(negedge clk);
    stop_on_fail = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_fcnt", 32'(fc1), 1);
    check("mid_busy", 32'(busy1), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vec", 32'(vec1), 0);
    check("arst_busy", 32'(busy1), 0);
    check("arst_done", 32'(done1), 0);
    check("arst_fd", 32'(fd1), 0);
    check("arst_fc", 32'(fc1), 0);
    check("arst_ffv", 32'(ffv1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1'b0, -1, cyc);
    check("post_cycles", 32'(cyc), 32);
    check("post_fcnt", 32'(fc1), 1);
    check("post_ffv", 32'(ffv1), 4'b0111);

    // T4 every vector fails, SETTLE=3
    run(1, 1'b0, -1, cyc);
    check("t4_cycles", 32'(cyc), 64);
    check("t4_fcnt", 32'(fc2), 5'b10000);
    check("t4_ffv", 32'(ffv2), 0);
    check("t4_fdet", 32'(fd2), 1);
    check("t4_vec", 32'(vec2), 4'hf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
